i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Byte-level I2C target (slave) engine on the `I2C_SCL` (input-only) and `I2C_SDA` (open-drain) pins.
- Sits directly upstream of the CPU bus I/O block, which arbitrates via its `BUS_I2C_TXN` state.
- Receives bytes written by an external I2C controller into a one-byte holding register for the CPU to read.
- Serves controller reads from a byte the CPU has staged.
- No clock stretching, because SCL cannot be driven.

Parameters:
- `I2C_ADDR`, `7'h42`: 7-bit target address this block answers to.

Ports:
- `CLK1`  in  1  system clock; every register clocks on its rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `SCL_IN`  in  1  raw `I2C_SCL` pin (asynchronous).
- `SDA_IN`  in  1  raw `I2C_SDA` pin (asynchronous).
- `SDA_OE`  out  1  1 = pull SDA low; the top level drives `I2C_SDA = SDA_OE ? 0 : 1'bz`.
- `RX_DATA`  out  8  last accepted write byte.
- `RX_VALID`  out  1  `RX_DATA` holds an unconsumed byte.
- `RX_FIRST`  out  1  `RX_DATA` is the first data byte after an address phase.
- `RX_ACK`  in  1  one-cycle pulse from the bus block: consume `RX_DATA`.
- `TX_DATA`  in  8  byte to return on the next controller read.
- `TX_VALID`  in  1  `TX_DATA` is staged.
- `TX_TAKEN`  out  1  one-cycle pulse: `TX_DATA` was loaded into the shifter.
- `ADDRESSED`  out  1  high from address ACK until STOP or repeated START.
- `STOP_DET`  out  1  one-cycle pulse on every STOP condition.

Behaviour:
- **Reset:** `RST_N` low, asynchronous; all outputs and state go to 0 and the state goes to IDLE. Reset mid-transfer releases SDA immediately.
- **Synchronisation and edges:**
  - `SCL_IN` and `SDA_IN` each pass through a 2-flop synchroniser, then one further register.
  - Edges are derived from the synchronised value vs. the previous one.
  - All detection latency is 2–3 `CLK1` after the pin edge.
- **START:** synchronised SDA falls while synchronised SCL is high.
- **STOP:** synchronised SDA rises while SCL is high. STOP is pulsed on `STOP_DET` even when not addressed.
- **Bit timing:**
  - SDA is sampled on the SCL rising edge, MSB first.
  - `SDA_OE` changes only on the detected SCL falling edge.
- **State machine:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the falling edge after bit 8, if `addr[7:1] == I2C_ADDR` go to ADDR_ACK and assert `SDA_OE`; otherwise go to IGNORE.
  - ADDR_ACK:
    - At the next falling edge release `SDA_OE` and set `ADDRESSED`.
    - If R/W = 0, go to RX and arm `RX_FIRST` for the next accepted byte.
    - If R/W = 1, load the shifter with `TX_DATA` (pulse `TX_TAKEN`) when `TX_VALID` is high, otherwise load `8'hFF`. Go to TX.
  - RX:
    - Shift 8 bits. On the falling edge after bit 8, the byte is accepted if `RX_VALID` is 0, or if `RX_ACK` is high in that same cycle.
    - On accept: `RX_DATA` ← byte, `RX_VALID` ← 1, `RX_FIRST` ← armed flag (then disarm), assert `SDA_OE`.
    - On reject: drop the byte and leave SDA released (NACK).
    - Either way, go to RX_ACK.
  - RX_ACK: on the next falling edge release `SDA_OE` and return to RX.
  - TX:
    - Drive `SDA_OE = ~shifter[7]` while SCL is low; shift on each falling edge.
    - After 8 bits release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the SCL rising edge.
    - Low (controller ACK): at the falling edge load the next byte (same `TX_VALID`/`8'hFF` rule, `TX_TAKEN` pulse) and go to TX.
    - High (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **START/STOP priority:**
  - START in any state clears the bit counter and goes to ADDR; this is the repeated START case.
  - STOP in any state goes to IDLE.
  - Both release `SDA_OE` and clear `ADDRESSED`.
  - START/STOP detection has priority over SCL edge processing in the same cycle.
- **`RX_VALID`:**
  - Cleared by `RX_ACK`.
  - If `RX_ACK` coincides with a new accept, `RX_VALID` stays 1 and carries the new data.
  - `RX_ACK` while `RX_VALID` is 0 is ignored.
- **Bit counter:** 3 bits, wrapping from 7 to 0, with a separate 9th-clock (ACK) phase held in state.

Test Plan:
- Controller writes addr `0x84` (`0x42` W), then `0x5A`, `0xC3`; CPU pulses `RX_ACK` between bytes → ACK on all 3 bytes; `RX_DATA` = `0x5A` with `RX_FIRST` = 1, then `0xC3` with `RX_FIRST` = 0; `ADDRESSED` = 1 until STOP; `STOP_DET` pulses once.
- Controller addresses `0x86` (`0x43` W) → `SDA_OE` never asserts; state IGNORE; `RX_VALID` stays 0; `STOP_DET` still pulses.
- Write `0x11` then `0x22` with no `RX_ACK` → ACK on `0x11`, NACK on `0x22`; `RX_DATA` remains `0x11`.
- Read addr `0x85` with `TX_VALID` = 1, `TX_DATA` = `0xA5`; controller ACKs, then NACKs the second byte with `TX_VALID` = 0 → SDA bits `10100101` then `11111111`; exactly one `TX_TAKEN` pulse; IGNORE after NACK.
- Write `0x84`, `0x10`, then repeated START with `0x85` → ACK on both address phases; the read returns the staged byte; `RX_FIRST` behaves correctly across the restart.
- Assert `RST_N` low while the target is driving ACK → `SDA_OE` drops to 0 in the same cycle; state IDLE; a following transaction with addr `0x84` is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - byte-level I2C target engine with one-byte RX holding register and staged TX byte
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic       CLK1,
  input  logic       RST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_FIRST,
  input  logic       RX_ACK,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_TAKEN,
  output logic       ADDRESSED,
  output logic       STOP_DET
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        done_q, done_d, rw_q, rw_d, mack_q, mack_d, armed_q, armed_d;
  logic        sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_taken_q, tx_taken_d, addressed_q, addressed_d, stop_det_q, stop_det_d;

  logic scl, scl_prev, sda, sda_prev, scl_rise, scl_fall, scl_high;
  logic start_cond, stop_cond, accept;
  logic [7:0] tx_byte;

  // Index 1 is the synchronised value, index 2 the previous one.
  assign scl      = scl_sync_q[1];
  assign scl_prev = scl_sync_q[2];
  assign sda      = sda_sync_q[1];
  assign sda_prev = sda_sync_q[2];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  // SCL must be high in both samples so the pins rising together out of reset never looks like STOP.
  assign scl_high   = scl & scl_prev;
  assign start_cond = scl_high & ~sda & sda_prev;
  assign stop_cond  = scl_high & sda & ~sda_prev;
  assign accept     = ~rx_valid_q | RX_ACK;
  assign tx_byte    = TX_VALID ? TX_DATA : 8'hFF;

  always_comb begin
    scl_sync_d  = {scl_sync_q[1:0], SCL_IN};
    sda_sync_d  = {sda_sync_q[1:0], SDA_IN};
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    armed_d     = armed_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~RX_ACK;
    rx_first_d  = rx_first_q;
    tx_taken_d  = 1'b0;
    addressed_d = addressed_q;
    stop_det_d  = stop_cond;

    if (start_cond || stop_cond) begin
      state_d     = start_cond ? ST_ADDR : ST_IDLE;
      cnt_d       = 3'd0;
      done_d      = 1'b0;
      armed_d     = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == I2C_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_RX_ACK;
              if (accept) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                rx_first_d = armed_q;
                armed_d    = 1'b0;
                sda_oe_d   = 1'b1;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            addressed_d = 1'b1;
            if (!rw_q) begin
              state_d  = ST_RX;
              armed_d  = 1'b1;
              sda_oe_d = 1'b0;
            end else begin
              state_d    = ST_TX;
              shift_d    = tx_byte;
              tx_taken_d = TX_VALID;
              sda_oe_d   = ~tx_byte[7];
              cnt_d      = 3'd0;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = ST_TX_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b1};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda;
          end else if (scl_fall) begin
            if (mack_q) begin
              state_d    = ST_TX;
              shift_d    = tx_byte;
              tx_taken_d = TX_VALID;
              sda_oe_d   = ~tx_byte[7];
              cnt_d      = 3'd0;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      scl_sync_q  <= 3'd0;
      sda_sync_q  <= 3'd0;
      cnt_q       <= 3'd0;
      shift_q     <= 8'd0;
      done_q      <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      armed_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_taken_q  <= 1'b0;
      addressed_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      armed_q     <= armed_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_taken_q  <= tx_taken_d;
      addressed_q <= addressed_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign SDA_OE    = sda_oe_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_FIRST  = rx_first_q;
  assign TX_TAKEN  = tx_taken_q;
  assign ADDRESSED = addressed_q;
  assign STOP_DET  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target: table of single-byte writes plus hand-written read, restart and reset sequences
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ack = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, rx_first, tx_taken, addressed, stop_det;
  logic [7:0] rx_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target #(.I2C_ADDR(7'h42)) dut (
    .CLK1(clk), .RST_N(rst_n), .SCL_IN(scl), .SDA_IN(sda_line), .SDA_OE(sda_oe),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_FIRST(rx_first), .RX_ACK(rx_ack),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_TAKEN(tx_taken),
    .ADDRESSED(addressed), .STOP_DET(stop_det)
  );

  int n_tests = 0;
  int n_fail = 0;
  int stop_cnt = 0;
  int taken_cnt = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (stop_det) stop_cnt++;
    if (tx_taken) taken_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    #Q scl = 1'b1;
    #Q r = sda_line;
    scl = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clock_bit(~mack, r);
  endtask

  task automatic bus_start();
    sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic pulse_rx_ack();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       ack_before;
    logic       exp_aack;
    logic       exp_dack;
    logic [7:0] exp_rxd;
    logic       exp_valid;
    logic       exp_first;
    logic       exp_oe;
    logic       exp_addressed;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       aack, dack, am, b;
    logic [7:0] d;
    int         s0, o0, t0;

    vecs[0] = '{8'h84, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h86, 8'h77, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h84, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h84, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h04, 8'h33, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hC4, 8'h44, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h84, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};

    #Q;
    chk("reset sda_oe", sda_oe, 0);
    chk("reset rx_valid", rx_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    #Q;
    chk("post-reset outputs", {sda_oe, rx_valid, rx_first, addressed, rx_data}, 0);
    chk("post-reset no phantom stop", stop_cnt, 0);
    chk("post-reset state", dut.state_q, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ack_before) pulse_rx_ack();
      s0 = stop_cnt;
      o0 = oe_cnt;
      bus_start();
      write_byte(vecs[i].addr, aack);
      am = addressed;
      write_byte(vecs[i].data, dack);
      bus_stop();
      chk($sformatf("v%0d addr ack", i), aack, vecs[i].exp_aack);
      chk($sformatf("v%0d data ack", i), dack, vecs[i].exp_dack);
      chk($sformatf("v%0d addressed", i), am, vecs[i].exp_addressed);
      chk($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_rxd);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d rx_first", i), rx_first, vecs[i].exp_first);
      chk($sformatf("v%0d oe seen", i), oe_cnt != o0, vecs[i].exp_oe);
      chk($sformatf("v%0d stop pulses", i), stop_cnt - s0, 1);
      chk($sformatf("v%0d addressed after stop", i), addressed, 0);
    end

    // Two-byte write with RX_ACK between, then an unconsumed third byte is refused.
    pulse_rx_ack();
    s0 = stop_cnt;
    bus_start();
    write_byte(8'h84, aack);
    chk("A addr ack", aack, 1);
    write_byte(8'h5A, dack);
    chk("A 5A ack", dack, 1);
    chk("A 5A data/first", {rx_data, rx_first, rx_valid}, {8'h5A, 1'b1, 1'b1});
    pulse_rx_ack();
    chk("A rx_valid cleared", rx_valid, 0);
    write_byte(8'hC3, dack);
    chk("A C3 ack", dack, 1);
    chk("A C3 data/first", {rx_data, rx_first, rx_valid}, {8'hC3, 1'b0, 1'b1});
    write_byte(8'h22, dack);
    chk("A 22 nack", dack, 0);
    chk("A data kept", rx_data, 8'hC3);
    chk("A addressed mid", addressed, 1);
    bus_stop();
    chk("A addressed after stop", addressed, 0);
    chk("A stop once", stop_cnt - s0, 1);

    // Read: staged A5, controller ACKs, then NACKs an unstaged byte.
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    t0 = taken_cnt;
    bus_start();
    write_byte(8'h85, aack);
    chk("B addr ack", aack, 1);
    tx_valid = 1'b0;
    read_byte(1'b1, d);
    chk("B byte1", d, 8'hA5);
    read_byte(1'b0, d);
    chk("B byte2", d, 8'hFF);
    chk("B tx_taken pulses", taken_cnt - t0, 1);
    chk("B state ignore", dut.state_q, 7);
    chk("B sda released", sda_oe, 0);
    bus_stop();

    // Write, restart as write (RX_FIRST re-arms), restart as read.
    pulse_rx_ack();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    t0 = taken_cnt;
    bus_start();
    write_byte(8'h84, aack);
    write_byte(8'h10, dack);
    chk("C 10 acks", {aack, dack}, 2'b11);
    chk("C 10 data/first", {rx_data, rx_first}, {8'h10, 1'b1});
    pulse_rx_ack();
    write_byte(8'h11, dack);
    chk("C 11 data/first", {dack, rx_data, rx_first}, {1'b1, 8'h11, 1'b0});
    pulse_rx_ack();
    bus_rstart();
    chk("C addressed cleared by restart", addressed, 0);
    write_byte(8'h84, aack);
    write_byte(8'h12, dack);
    chk("C 12 acks/data/first", {aack, dack, rx_data, rx_first}, {2'b11, 8'h12, 1'b1});
    bus_rstart();
    write_byte(8'h85, aack);
    chk("C read addr ack", aack, 1);
    tx_valid = 1'b0;
    read_byte(1'b0, d);
    chk("C read byte", d, 8'h3C);
    chk("C tx_taken pulses", taken_cnt - t0, 1);
    bus_stop();

    // Reset while the target pulls SDA for the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h84;
      clock_bit(d[i], b);
    end
    chk("D driving ack", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("D sda_oe drops at reset", sda_oe, 0);
    scl = 1'b1;
    sda_m = 1'b1;
    #Q;
    @(negedge clk) rst_n = 1'b1;
    #Q;
    chk("D state idle", dut.state_q, 0);
    chk("D outputs cleared", {addressed, rx_valid, rx_data}, 0);
    bus_start();
    write_byte(8'h84, aack);
    write_byte(8'h66, dack);
    bus_stop();
    chk("D follow-up acks", {aack, dack}, 2'b11);
    chk("D follow-up data/first", {rx_data, rx_first, rx_valid}, {8'h66, 1'b1, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
